// File: rtl/alu_iter_if.sv
// Request/result handshake bundle between issue, alu_iter and writeback.
interface alu_iter_if #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned INST_WIDTH = 4
);
    logic [DATA_WIDTH-1:0] i_data_a;
    logic [DATA_WIDTH-1:0] i_data_b;
    logic [INST_WIDTH-1:0] i_inst;
    logic                  i_valid;
    logic                  o_ready;
    logic [DATA_WIDTH-1:0] o_data;
    logic                  o_overflow;
    logic                  o_valid;
    logic                  i_ready;

    modport master (
        output i_data_a, i_data_b, i_inst, i_valid, i_ready,
        input  o_ready, o_data, o_overflow, o_valid
    );

    modport slave (
        input  i_data_a, i_data_b, i_inst, i_valid, i_ready,
        output o_ready, o_data, o_overflow, o_valid
    );
endinterface

// File: rtl/alu_iter.sv
// Multi-cycle ALU with valid/ready handshakes; iterative shift-add multiply
// and restoring unsigned divide share one hi/lo register pair.
module alu_iter #(
    parameter int unsigned DATA_WIDTH = 32,
    parameter int unsigned INST_WIDTH = 4
) (
    input logic        i_clk,
    input logic        i_rst_n,
    alu_iter_if.slave  bus
);
    localparam int unsigned W  = DATA_WIDTH;
    localparam int unsigned CW = $clog2(DATA_WIDTH);

    typedef enum logic [1:0] {IDLE, BUSY, DONE} state_t;
    typedef enum logic [INST_WIDTH-1:0] {
        OP_ADD  = 0,  OP_SUB  = 1,  OP_MUL  = 2,  OP_MAX  = 3,
        OP_MIN  = 4,  OP_ADDU = 5,  OP_SUBU = 6,  OP_MULU = 7,
        OP_DIVU = 8,  OP_REMU = 9,  OP_AND  = 10, OP_OR   = 11,
        OP_XOR  = 12, OP_NOT  = 13, OP_BREV = 14, OP_RSVD = 15
    } op_t;

    state_t         state, state_n;
    op_t            op_in, op_r;
    logic [W-1:0]   a, b, mag_a, mag_b;
    logic [W:0]     sum;
    logic [W-1:0]   dif;
    logic [W-1:0]   res_sc, res_it, res_r;
    logic           ovf_sc, ovf_it, ovf_r;
    logic           iter_in, is_div, neg_r;
    logic [CW-1:0]  cnt;
    logic [W-1:0]   hi, lo, b_r, hi_nx, lo_nx;
    logic [W:0]     msum, dsh;
    logic           dge;
    logic [2*W-1:0] prod, prod_s;

    assign a       = bus.i_data_a;
    assign b       = bus.i_data_b;
    assign op_in   = op_t'(bus.i_inst);
    assign sum     = {1'b0, a} + {1'b0, b};
    assign dif     = a - b;
    assign mag_a   = a[W-1] ? -a : a;
    assign mag_b   = b[W-1] ? -b : b;
    assign iter_in = op_in inside {OP_MUL, OP_MULU, OP_DIVU, OP_REMU};

    always_comb begin
        res_sc = '0;
        ovf_sc = 1'b0;
        case (op_in)
            OP_ADD: begin
                res_sc = sum[W-1:0];
                ovf_sc = (a[W-1] == b[W-1]) && (sum[W-1] != a[W-1]);
            end
            OP_SUB: begin
                res_sc = dif;
                ovf_sc = (a[W-1] != b[W-1]) && (dif[W-1] != a[W-1]);
            end
            OP_MAX:  res_sc = ($signed(a) > $signed(b)) ? a : b;
            OP_MIN:  res_sc = ($signed(a) < $signed(b)) ? a : b;
            OP_ADDU: begin
                res_sc = sum[W-1:0];
                ovf_sc = sum[W];
            end
            OP_SUBU: begin
                res_sc = dif;
                ovf_sc = (a < b);
            end
            OP_AND:  res_sc = a & b;
            OP_OR:   res_sc = a | b;
            OP_XOR:  res_sc = a ^ b;
            OP_NOT:  res_sc = ~a;
            OP_BREV: for (int unsigned i = 0; i < W; i++) res_sc[i] = a[W-1-i];
            default: ;
        endcase
    end

    // Multiply: hi accumulates, lo holds the multiplier and collects product
    // low bits. Divide: hi is the partial remainder, lo shifts the dividend
    // out and quotient bits in. A zero divisor naturally yields all-ones / A.
    assign is_div = (op_r == OP_DIVU) || (op_r == OP_REMU);
    assign msum   = {1'b0, hi} + (lo[0] ? {1'b0, b_r} : '0);
    assign dsh    = {hi, lo[W-1]};
    assign dge    = dsh >= {1'b0, b_r};

    always_comb begin
        if (is_div) begin
            hi_nx = dge ? (dsh[W-1:0] - b_r) : dsh[W-1:0];
            lo_nx = {lo[W-2:0], dge};
        end else begin
            hi_nx = msum[W:1];
            lo_nx = {msum[0], lo[W-1:1]};
        end
    end

    assign prod   = {hi_nx, lo_nx};
    assign prod_s = neg_r ? -prod : prod;

    always_comb begin
        res_it = '0;
        ovf_it = 1'b0;
        case (op_r)
            OP_MUL: begin
                res_it = prod_s[W-1:0];
                ovf_it = ~((&prod_s[2*W-1:W-1]) | ~(|prod_s[2*W-1:W-1]));
            end
            OP_MULU: begin
                res_it = lo_nx;
                ovf_it = |hi_nx;
            end
            OP_DIVU: begin
                res_it = lo_nx;
                ovf_it = ~(|b_r);
            end
            OP_REMU: begin
                res_it = hi_nx;
                ovf_it = ~(|b_r);
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) state <= IDLE;
        else          state <= state_n;
    end

    always_comb begin
        state_n     = state;
        bus.o_ready = 1'b0;
        bus.o_valid = 1'b0;
        case (state)
            IDLE: begin
                bus.o_ready = 1'b1;
                if (bus.i_valid) state_n = iter_in ? BUSY : DONE;
            end
            BUSY: if (cnt == '0) state_n = DONE;
            DONE: begin
                bus.o_valid = 1'b1;
                if (bus.i_ready) state_n = IDLE;
            end
            default: state_n = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            op_r  <= OP_ADD;
            cnt   <= '0;
            hi    <= '0;
            lo    <= '0;
            b_r   <= '0;
            neg_r <= 1'b0;
            res_r <= '0;
            ovf_r <= 1'b0;
        end else begin
            case (state)
                IDLE: if (bus.i_valid) begin
                    op_r <= op_in;
                    cnt  <= CW'(W - 1);
                    if (iter_in) begin
                        hi    <= '0;
                        lo    <= (op_in == OP_MUL) ? mag_a : a;
                        b_r   <= (op_in == OP_MUL) ? mag_b : b;
                        neg_r <= (op_in == OP_MUL) && (a[W-1] ^ b[W-1]);
                    end else begin
                        res_r <= res_sc;
                        ovf_r <= ovf_sc;
                    end
                end
                BUSY: begin
                    cnt <= cnt - 1'b1;
                    hi  <= hi_nx;
                    lo  <= lo_nx;
                    if (cnt == '0) begin
                        res_r <= res_it;
                        ovf_r <= ovf_it;
                    end
                end
                default: ;
            endcase
        end
    end

    assign bus.o_data     = res_r;
    assign bus.o_overflow = ovf_r;
endmodule

// File: doc/alu_iter.md
Name: alu_iter

Overview:
- Parametrised, multi-cycle successor to the single-cycle registered ALU.
- Adds valid/ready handshakes on both the input and output sides, plus output backpressure.
- Adds an iterative shift-add multiplier and restoring divider (unsigned DIVU/REMU), so no combinational W×W multiplier is required.
- Sits between the instruction issue stage and the writeback stage. Holds one operation in flight.

Parameters:
- DATA_WIDTH, 32, operand/result width W; legal values 8..64.
- INST_WIDTH, 4, opcode width; fixed at 4 for this opcode map.

Ports:
- i_clk  input  1  clock; all state changes on its rising edge.
- i_rst_n  input  1  asynchronous active-low reset.
- i_data_a  input  DATA_WIDTH  operand A.
- i_data_b  input  DATA_WIDTH  operand B.
- i_inst  input  INST_WIDTH  opcode.
- i_valid  input  1  upstream request valid.
- o_ready  output  1  block can accept a request.
- o_data  output  DATA_WIDTH  result.
- o_overflow  output  1  overflow / divide-by-zero flag.
- o_valid  output  1  result valid.
- i_ready  input  1  downstream accepts the result.

Behaviour:
- Clock and reset (decided): one clock, i_clk. Reset is asynchronous, active-low, on i_rst_n.
- Reset values: state=IDLE; o_ready=1; o_valid=0; o_data=0; o_overflow=0; counter and all datapath registers=0.
- Reset mid-operation: the operation in flight is abandoned and no result is produced.
- FSM states: IDLE, BUSY, DONE.
  - o_ready=1 only in IDLE. o_valid=1 only in DONE.
- Input accept: occurs at a rising edge with state IDLE and i_valid=1. Operands and opcode are latched at that edge.
- Single-cycle opcodes:
  - Result computed from latched inputs; IDLE→DONE at the accept edge.
  - o_valid is high in the cycle right after accept, i.e. latency 1.
- MUL, MULU, DIVU, REMU:
  - IDLE→BUSY at accept. Counter loads W-1.
  - Exactly one iteration per cycle for W cycles.
  - BUSY→DONE when the counter reaches 0, so o_valid rises W+1 cycles after the accept edge.
- Output hold (DONE):
  - o_data and o_overflow stay stable while i_ready=0.
  - When i_ready=1 at an edge: DONE→IDLE and o_valid drops.
  - No new request is accepted in that same edge, so peak throughput is one operation per 2 cycles.
- i_valid while BUSY/DONE: ignored. Upstream must hold the request until it sees o_ready.
- Opcode map (s = two's-complement signed, u = unsigned):
  - 0 ADD(s): overflow = operands have the same sign and the result sign differs.
  - 1 SUB(s): overflow = operands have different signs and the result sign differs from A.
  - 2 MUL(s), iterative:
    - Operands converted to magnitudes; shift-add builds the 2W-bit product; negated if the signs differ.
    - o_data = low W bits. overflow = 1 unless product bits [2W-1:W-1] are all equal.
  - 3 MAX(s); 4 MIN(s): overflow=0.
  - 5 ADDU: overflow = carry out of bit W-1.
  - 6 SUBU: overflow = (A<B). Data wraps modulo 2^W.
  - 7 MULU, iterative: o_data = low W bits of the product; overflow = (high W bits ≠ 0).
  - 8 DIVU, iterative restoring division: o_data = quotient.
  - 9 REMU, iterative restoring division: o_data = remainder.
  - DIVU/REMU by B=0:
    - Still runs W cycles.
    - DIVU returns all-ones; REMU returns A; overflow=1.
  - 10 AND; 11 OR; 12 XOR; 13 NOT A; 14 bit-reverse A (bit i ← bit W-1-i): overflow=0.
  - 15 reserved: o_data=0, overflow=0. Still handshakes with latency 1.
- MAX/MIN tie: returns B (equal values, so the result is identical either way).
- Signed MUL with A = -2^(W-1), B = 1: the magnitude 2^(W-1) fits in W unsigned bits, so the result is exact with overflow=0.

Test Plan:
- Add edge case:
  - W=32, accept ADD A=0x7FFFFFFF, B=0x00000001 with i_ready=1.
  - Required: next cycle o_valid=1, o_data=0x80000000, o_overflow=1; following cycle o_valid=0, o_ready=1.
- Multiply pair:
  - MUL A=0xFFFFFFFD (-3), B=5: o_valid exactly 33 cycles after accept, o_data=0xFFFFFFF1, o_overflow=0, o_ready=0 throughout BUSY.
  - Then MULU 0x00010000×0x00010000: o_data=0, o_overflow=1.
- Divide pair:
  - DIVU 100/7 → o_data=14, overflow=0. REMU 100/7 → o_data=2.
  - DIVU 5/0 → 0xFFFFFFFF, overflow=1. REMU 5/0 → 5, overflow=1.
- Backpressure:
  - XOR 0xF0F0F0F0^0xFF00FF00 with i_ready=0 for 5 cycles after o_valid rises.
  - Required: o_data=0x0FF00FF0 stable, o_valid=1, o_ready=0, and a pulsed i_valid carrying a different op is ignored.
  - Raise i_ready → IDLE on the next edge.
- Reset mid-operation:
  - Assert i_rst_n=0 asynchronously mid-cycle, 10 cycles into a MULU.
  - Required: outputs clear immediately (o_valid=0, o_data=0, o_ready=1) and no result appears after release.
  - A following BITREV of 0x00000001 → 0x80000000.
- Parametrisation: DATA_WIDTH=8, MUL 0x10 (16) × 0x08 (8) → o_data=0x80, overflow=1, o_valid 9 cycles after accept.
